// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter: FSM states, result width
// and the saturating count-to-Hz scaling.
package freq_meter_pkg;

    localparam int unsigned SPEED_W = 20;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        REPORT
    } fm_state_e;

    typedef struct packed {
        logic               ovf;
        logic [SPEED_W-1:0] speed;
    } fm_result_t;

    // Product is formed at 64 bits so a full-scale count times a large
    // divisor cannot wrap before the saturation compare.
    function automatic fm_result_t sat_scale(input logic [SPEED_W-1:0] count,
                                             input logic [31:0]        div);
        logic [63:0] prod;
        fm_result_t  res;
        prod = {44'd0, count} * {32'd0, div};
        if (prod > {44'd0, SPEED_MAX}) begin
            res.ovf   = 1'b1;
            res.speed = SPEED_MAX;
        end else begin
            res.ovf   = 1'b0;
            res.speed = prod[SPEED_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/freq_meter_edge.sv
// Synchronizes an asynchronous input into the clk domain and emits a one-cycle
// pulse on each rising edge. Latency is SYNC_STAGES+1 clk to the consumer.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("edge_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over BASESPEED/GATE_DIV clk
// cycles and reports the count scaled to Hz, saturating at 20 bits.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned BASESPEED   = 50000000,
    parameter int unsigned GATE_DIV    = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [SPEED_W-1:0] speed,
    output logic               speed_valid,
    output logic               overflow
);

    localparam int unsigned GATE_CYCLES = BASESPEED / GATE_DIV;
    localparam logic [31:0] GATE_LAST   = GATE_CYCLES - 1;

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("freq_meter: BASESPEED/GATE_DIV must be >= 2");
    end

    fm_state_e          r_state;
    logic [31:0]        r_gate_cnt;
    logic [SPEED_W-1:0] r_edge_cnt;
    logic [SPEED_W-1:0] r_speed;
    logic               r_speed_valid;
    logic               r_overflow;

    logic               w_rise;
    logic               w_gate_done;
    fm_result_t         w_scaled;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(sig_in),
        .o_rise (w_rise)
    );

    assign w_gate_done = (r_gate_cnt == GATE_LAST);
    assign w_scaled    = sat_scale(r_edge_cnt, GATE_DIV);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_speed_valid <= 1'b0;
            if (!en) begin
                // Partial window is dropped; results hold until the next report.
                r_state    <= IDLE;
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= ARM;
                        r_gate_cnt <= '0;
                    end
                    ARM: begin
                        if (w_rise) begin
                            // Aligning edge opens the window and is not itself counted.
                            r_state    <= MEASURE;
                            r_gate_cnt <= '0;
                            r_edge_cnt <= '0;
                        end else if (w_gate_done) begin
                            r_gate_cnt    <= '0;
                            r_speed       <= '0;
                            r_overflow    <= 1'b0;
                            r_speed_valid <= 1'b1;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + 32'd1;
                        end
                    end
                    MEASURE: begin
                        if (w_rise && (r_edge_cnt != SPEED_MAX)) begin
                            r_edge_cnt <= r_edge_cnt + 20'd1;
                        end
                        if (w_gate_done) begin
                            r_state <= REPORT;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + 32'd1;
                        end
                    end
                    REPORT: begin
                        r_speed       <= w_scaled.speed;
                        r_overflow    <= w_scaled.ovf;
                        r_speed_valid <= 1'b1;
                        r_gate_cnt    <= '0;
                        r_edge_cnt    <= w_rise ? 20'd1 : 20'd0;
                        r_state       <= MEASURE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign speed       = r_speed;
    assign speed_valid = r_speed_valid;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: instance A (100-cycle window, x10 scale)
// and instance B (100-cycle window, x100000 scale, saturating).
module tb_freq_meter;

    typedef struct packed {
        logic        ovf;
        logic [19:0] speed;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en_a, en_b;
    logic        sig_a, sig_b;
    logic [19:0] speed_a, speed_b;
    logic        valid_a, valid_b;
    logic        ovf_a, ovf_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int per_a    = 0;
    int per_b    = 0;
    int ph_a     = 0;
    int ph_b     = 0;
    int last_t_a = 0;
    int prev_t_a = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    logic [19:0] prev_speed_a, prev_speed_b;
    logic        prev_valid_a, prev_valid_b;

    freq_meter #(
        .BASESPEED  (1000),
        .GATE_DIV   (10),
        .SYNC_STAGES(2)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en_a),
        .sig_in     (sig_a),
        .speed      (speed_a),
        .speed_valid(valid_a),
        .overflow   (ovf_a)
    );

    freq_meter #(
        .BASESPEED  (10000000),
        .GATE_DIV   (100000),
        .SYNC_STAGES(2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en_b),
        .sig_in     (sig_b),
        .speed      (speed_b),
        .speed_valid(valid_b),
        .overflow   (ovf_b)
    );

    initial begin
        clk = 1'b0;
        #5;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Square-wave generators; a period of 0 holds the signal low.
    initial begin
        sig_a = 1'b0;
        forever begin
            @(negedge clk);
            if (per_a == 0) begin
                sig_a = 1'b0;
                ph_a  = 0;
            end else begin
                ph_a++;
                if (ph_a >= per_a / 2) begin
                    sig_a = ~sig_a;
                    ph_a  = 0;
                end
            end
        end
    end

    initial begin
        sig_b = 1'b0;
        forever begin
            @(negedge clk);
            if (per_b == 0) begin
                sig_b = 1'b0;
                ph_b  = 0;
            end else begin
                ph_b++;
                if (ph_b >= per_b / 2) begin
                    sig_b = ~sig_b;
                    ph_b  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (valid_a) begin
                prev_t_a = last_t_a;
                last_t_a = cyc;
                check("a_valid_not_b2b", {31'd0, prev_valid_a}, 32'd0);
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_speed", {12'd0, speed_a}, {12'd0, e_a.speed});
                    check("a_ovf", {31'd0, ovf_a}, {31'd0, e_a.ovf});
                end
            end
            if (speed_a != prev_speed_a) check("a_speed_chg_needs_valid", {31'd0, valid_a}, 32'd1);
        end
        prev_speed_a = speed_a;
        prev_valid_a = valid_a;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (valid_b) begin
                check("b_valid_not_b2b", {31'd0, prev_valid_b}, 32'd0);
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e_b = q_b.pop_front();
                    check("b_speed", {12'd0, speed_b}, {12'd0, e_b.speed});
                    check("b_ovf", {31'd0, ovf_b}, {31'd0, e_b.ovf});
                end
            end
            if (speed_b != prev_speed_b) check("b_speed_chg_needs_valid", {31'd0, valid_b}, 32'd1);
        end
        prev_speed_b = speed_b;
        prev_valid_b = valid_b;
    end

    // Waits until the selected queue has been consumed, within a cycle budget.
    task automatic wait_drain(input int which, input int budget);
        int left;
        left = (which == 0) ? q_a.size() : q_b.size();
        for (int i = 0; i < budget && left != 0; i++) begin
            @(posedge clk);
            #1;
            left = (which == 0) ? q_a.size() : q_b.size();
        end
        check((which == 0) ? "a_drain" : "b_drain", left, 32'd0);
        if (which == 0) q_a.delete();
        else q_b.delete();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        en_a = 1'b0;
        en_b = 1'b0;
        rst  = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_speed", {12'd0, speed_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_ovf", {31'd0, ovf_a}, 32'd0);
        wait_cycles(5);
        check("rst_hold_speed", {12'd0, speed_a}, 32'd0);
        check("rst_hold_valid", {31'd0, valid_a}, 32'd0);
        check("rst_hold_ovf_b", {31'd0, ovf_b}, 32'd0);
        rst = 1'b1;
        wait_cycles(2);

        // Period-10 input: two back-to-back windows of 10 edges each.
        per_a = 10;
        en_a  = 1'b1;
        q_a.push_back('{ovf: 1'b0, speed: 20'd100});
        q_a.push_back('{ovf: 1'b0, speed: 20'd100});
        wait_drain(0, 400);
        check("a_valid_spacing", last_t_a - prev_t_a, 32'd101);

        // Disable mid-window: nothing reported, result holds.
        wait_cycles(50);
        en_a = 1'b0;
        wait_cycles(300);
        check("a_hold_speed", {12'd0, speed_a}, 32'd100);
        check("a_hold_ovf", {31'd0, ovf_a}, 32'd0);
        en_a = 1'b1;
        q_a.push_back('{ovf: 1'b0, speed: 20'd100});
        wait_drain(0, 300);

        // Reset mid-measurement, then recover through ARM.
        wait_cycles(40);
        #1 rst = 1'b0;
        #1;
        check("a_midrst_speed", {12'd0, speed_a}, 32'd0);
        check("a_midrst_ovf", {31'd0, ovf_a}, 32'd0);
        check("a_midrst_valid", {31'd0, valid_a}, 32'd0);
        wait_cycles(3);
        rst = 1'b1;
        q_a.push_back('{ovf: 1'b0, speed: 20'd100});
        wait_drain(0, 300);
        en_a  = 1'b0;
        per_a = 0;
        wait_cycles(5);

        // Stuck input: ARM timeouts report 0, then a period-20 input gives 50 Hz.
        en_a = 1'b1;
        repeat (3) q_a.push_back('{ovf: 1'b0, speed: 20'd0});
        wait_drain(0, 400);
        per_a = 20;
        q_a.push_back('{ovf: 1'b0, speed: 20'd50});
        wait_drain(0, 300);
        en_a  = 1'b0;
        per_a = 0;
        wait_cycles(5);

        // Instance B: 25 edges * 100000 saturates.
        per_b = 4;
        en_b  = 1'b1;
        q_b.push_back('{ovf: 1'b1, speed: 20'hFFFFF});
        q_b.push_back('{ovf: 1'b1, speed: 20'hFFFFF});
        wait_drain(1, 400);
        en_b  = 1'b0;
        per_b = 0;
        wait_cycles(5);
        check("b_hold_ovf", {31'd0, ovf_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
